// File: rtl/contador_bcd_updown_pkg.sv
// Shared BCD constants and the load clamp helper for the up/down BCD counter.
package contador_bcd_updown_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

    // Out-of-range load digits saturate to 9 so q never holds a non-BCD nibble.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/contador_bcd_updown_digit_step.sv
// One BCD digit of the counter: increment/decrement with carry/borrow in and out.
module bcd_digit_step
    import contador_bcd_updown_pkg::*;
(
    input  logic [BCD_W-1:0] d_in,
    input  logic             up,
    input  logic             cin,
    output logic [BCD_W-1:0] d_out,
    output logic             cout
);

    always_comb begin
        d_out = d_in;
        cout  = 1'b0;
        if (cin) begin
            if (up) begin
                if (d_in == BCD_MAX) begin
                    d_out = BCD_MIN;
                    cout  = 1'b1;
                end else begin
                    d_out = d_in + BCD_W'(1);
                end
            end else begin
                if (d_in == BCD_MIN) begin
                    d_out = BCD_MAX;
                    cout  = 1'b1;
                end else begin
                    d_out = d_in - BCD_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/contador_bcd_updown.sv
// Multi-digit BCD up/down counter with enable, parallel load, soft clear and wrap/saturate mode.
module contador_bcd_updown
    import contador_bcd_updown_pkg::*;
#(
    parameter int unsigned ND   = 3,
    parameter bit          WRAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [BCD_W*ND-1:0] d,
    output logic [BCD_W*ND-1:0] q,
    output logic               max_tick,
    output logic               min_tick,
    output logic               ovf,
    output logic               load_err
);

    localparam int unsigned QW = BCD_W * ND;

    logic [QW-1:0] q_q, q_d;
    logic          ovf_q, ovf_d;
    logic          lerr_q, lerr_d;
    logic [QW-1:0] step_val;
    logic [QW-1:0] load_val;
    logic [ND:0]   carry;
    logic [ND-1:0] digit_bad;
    logic [ND-1:0] digit_nine;

    // Enable enters the chain as carry-in of the LSD; carry out of the MSD marks a limit.
    assign carry[0] = en;

    for (genvar k = 0; k < ND; k++) begin : g_digit
        bcd_digit_step u_step (
            .d_in  (q_q[k*BCD_W +: BCD_W]),
            .up    (up),
            .cin   (carry[k]),
            .d_out (step_val[k*BCD_W +: BCD_W]),
            .cout  (carry[k+1])
        );
        assign digit_bad[k]                = d[k*BCD_W +: BCD_W] > BCD_MAX;
        assign load_val[k*BCD_W +: BCD_W]  = bcd_clamp(d[k*BCD_W +: BCD_W]);
        assign digit_nine[k]               = q_q[k*BCD_W +: BCD_W] == BCD_MAX;
    end

    // Priority: soft clear, load, count, hold. Pulses default low every cycle.
    always_comb begin
        q_d    = q_q;
        ovf_d  = 1'b0;
        lerr_d = 1'b0;
        if (soft_reset) begin
            q_d = '0;
        end else if (load) begin
            q_d    = load_val;
            lerr_d = |digit_bad;
        end else if (en) begin
            ovf_d = carry[ND];
            // The chain already wraps 99..9 <-> 0; saturate mode just refuses the step.
            if (WRAP || !carry[ND]) begin
                q_d = step_val;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q    <= '0;
            ovf_q  <= 1'b0;
            lerr_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            ovf_q  <= ovf_d;
            lerr_q <= lerr_d;
        end
    end

    assign q        = q_q;
    assign ovf      = ovf_q;
    assign load_err = lerr_q;
    assign max_tick = &digit_nine;
    assign min_tick = (q_q == '0);

endmodule

// File: tb/tb_contador_bcd_updown.sv
// Directed self-checking bench: ND=3 wrap and saturate instances plus an ND=1 sweep instance.
module tb_contador_bcd_updown;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        soft_reset = 1'b0, en = 1'b0, up = 1'b0, load = 1'b0;
    logic [11:0] d = '0;
    logic [11:0] q_w, q_s;
    logic        max_w, min_w, ovf_w, lerr_w;
    logic        max_s, min_s, ovf_s, lerr_s;

    logic        soft1 = 1'b0, en1 = 1'b0, up1 = 1'b0, load1 = 1'b0;
    logic [3:0]  d1 = '0;
    logic [3:0]  q1;
    logic        max1, min1, ovf1, lerr1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    contador_bcd_updown #(.ND(3), .WRAP(1'b1)) dut_w (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .en(en), .up(up), .load(load),
        .d(d), .q(q_w), .max_tick(max_w), .min_tick(min_w), .ovf(ovf_w), .load_err(lerr_w)
    );

    contador_bcd_updown #(.ND(3), .WRAP(1'b0)) dut_s (
        .clk(clk), .reset(reset), .soft_reset(soft_reset), .en(en), .up(up), .load(load),
        .d(d), .q(q_s), .max_tick(max_s), .min_tick(min_s), .ovf(ovf_s), .load_err(lerr_s)
    );

    contador_bcd_updown #(.ND(1), .WRAP(1'b1)) dut_1 (
        .clk(clk), .reset(reset), .soft_reset(soft1), .en(en1), .up(up1), .load(load1),
        .d(d1), .q(q1), .max_tick(max1), .min_tick(min1), .ovf(ovf1), .load_err(lerr1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (q_w !== 12'h000) begin errors++; $display("FAIL reset_q got=%h exp=000", q_w); end
        checks++;
        if ({ovf_w, lerr_w, max_w, min_w} !== 4'b0001) begin
            errors++; $display("FAIL reset_flags got=%b exp=0001", {ovf_w, lerr_w, max_w, min_w});
        end
        checks++;
        if (q1 !== 4'h0 || min1 !== 1'b1) begin errors++; $display("FAIL reset_nd1 q=%h min=%b exp=0/1", q1, min1); end
        reset = 1'b0;
    endtask

    task automatic test_load_count();
        logic [11:0] exp_q [3];
        exp_q[0] = 12'h099; exp_q[1] = 12'h100; exp_q[2] = 12'h101;
        load = 1'b1; d = 12'h098;
        step();
        load = 1'b0;
        checks++;
        if (q_w !== 12'h098) begin errors++; $display("FAIL load_098 got=%h exp=098", q_w); end
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q_w !== exp_q[i] || ovf_w !== 1'b0) begin
                errors++; $display("FAIL count_up%0d q=%h ovf=%b exp=%h/0", i, q_w, ovf_w, exp_q[i]);
            end
        end
        en = 1'b0;
    endtask

    task automatic test_reset_mid();
        load = 1'b1; d = 12'h457;
        step();
        load = 1'b0;
        checks++;
        if (q_w !== 12'h457) begin errors++; $display("FAIL load_457 got=%h exp=457", q_w); end
        en = 1'b1; up = 1'b1;
        step();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (q_w !== 12'h000 || ovf_w !== 1'b0 || min_w !== 1'b1) begin
            errors++; $display("FAIL async_reset q=%h ovf=%b min=%b exp=000/0/1", q_w, ovf_w, min_w);
        end
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic test_wrap();
        load = 1'b1; d = 12'h999;
        step();
        load = 1'b0;
        checks++;
        if (max_w !== 1'b1 || min_w !== 1'b0) begin errors++; $display("FAIL max_tick got=%b%b exp=10", max_w, min_w); end
        en = 1'b1; up = 1'b1;
        step();
        checks++;
        if (q_w !== 12'h000 || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_up q=%h ovf=%b exp=000/1", q_w, ovf_w); end
        checks++;
        if (q_s !== 12'h999 || ovf_s !== 1'b1) begin errors++; $display("FAIL sat_up q=%h ovf=%b exp=999/1", q_s, ovf_s); end
        up = 1'b0;
        step();
        checks++;
        if (q_w !== 12'h999 || ovf_w !== 1'b1) begin errors++; $display("FAIL wrap_down q=%h ovf=%b exp=999/1", q_w, ovf_w); end
        checks++;
        if (q_s !== 12'h998 || ovf_s !== 1'b0) begin errors++; $display("FAIL sat_mid q=%h ovf=%b exp=998/0", q_s, ovf_s); end
        en = 1'b0;
        step();
        checks++;
        if (q_w !== 12'h999 || ovf_w !== 1'b0) begin errors++; $display("FAIL ovf_pulse q=%h ovf=%b exp=999/0", q_w, ovf_w); end
    endtask

    task automatic test_saturate();
        logic [11:0] exp_w [3];
        exp_w[0] = 12'h000; exp_w[1] = 12'h999; exp_w[2] = 12'h998;
        load = 1'b1; d = 12'h001;
        step();
        load = 1'b0;
        en = 1'b1; up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (q_s !== 12'h000 || ovf_s !== (i > 0)) begin
                errors++; $display("FAIL sat_down%0d q=%h ovf=%b exp=000/%0d", i, q_s, ovf_s, (i > 0));
            end
            checks++;
            if (q_w !== exp_w[i] || ovf_w !== (i == 1)) begin
                errors++; $display("FAIL wrap_down%0d q=%h ovf=%b exp=%h/%0d", i, q_w, ovf_w, exp_w[i], (i == 1));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_load_err();
        load = 1'b1; en = 1'b1; up = 1'b1; d = 12'h3A7;
        step();
        load = 1'b0; en = 1'b0;
        checks++;
        if (q_w !== 12'h397 || lerr_w !== 1'b1 || ovf_w !== 1'b0) begin
            errors++; $display("FAIL load_err q=%h lerr=%b ovf=%b exp=397/1/0", q_w, lerr_w, ovf_w);
        end
        step();
        checks++;
        if (q_w !== 12'h397 || lerr_w !== 1'b0) begin
            errors++; $display("FAIL load_err_pulse q=%h lerr=%b exp=397/0", q_w, lerr_w);
        end
        load = 1'b1; d = 12'hFB0;
        step();
        load = 1'b0;
        checks++;
        if (q_w !== 12'h990 || lerr_w !== 1'b1) begin
            errors++; $display("FAIL clamp_hi q=%h lerr=%b exp=990/1", q_w, lerr_w);
        end
        load = 1'b1; d = 12'h246;
        step();
        load = 1'b0;
        checks++;
        if (q_w !== 12'h246 || lerr_w !== 1'b0) begin
            errors++; $display("FAIL load_ok q=%h lerr=%b exp=246/0", q_w, lerr_w);
        end
    endtask

    task automatic test_soft_reset();
        load = 1'b1; d = 12'h123;
        step();
        soft_reset = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; d = 12'h555;
        step();
        soft_reset = 1'b0; load = 1'b0; en = 1'b0;
        checks++;
        if (q_w !== 12'h000 || ovf_w !== 1'b0 || lerr_w !== 1'b0) begin
            errors++; $display("FAIL soft_load q=%h ovf=%b lerr=%b exp=000/0/0", q_w, ovf_w, lerr_w);
        end
        load = 1'b1; d = 12'h999;
        step();
        load = 1'b0;
        soft_reset = 1'b1; en = 1'b1; up = 1'b1;
        step();
        soft_reset = 1'b0; en = 1'b0;
        checks++;
        if (q_w !== 12'h000 || ovf_w !== 1'b0 || q_s !== 12'h000 || ovf_s !== 1'b0) begin
            errors++; $display("FAIL soft_en qw=%h ow=%b qs=%h os=%b exp=000/0", q_w, ovf_w, q_s, ovf_s);
        end
        soft_reset = 1'b1; load = 1'b1; d = 12'hA5C;
        step();
        soft_reset = 1'b0; load = 1'b0;
        checks++;
        if (q_w !== 12'h000 || lerr_w !== 1'b0) begin
            errors++; $display("FAIL soft_baddig q=%h lerr=%b exp=000/0", q_w, lerr_w);
        end
    endtask

    task automatic test_nd1_sweep();
        logic [3:0] exp;
        soft1 = 1'b1;
        step();
        soft1 = 1'b0;
        en1 = 1'b1; up1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = 4'((i + 1) % 10);
            checks++;
            if (q1 !== exp || ovf1 !== (i == 9) || max1 !== (exp == 4'd9)) begin
                errors++; $display("FAIL nd1_up%0d q=%h ovf=%b max=%b exp=%h/%0d", i, q1, ovf1, max1, exp, (i == 9));
            end
        end
        up1 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            exp = 4'(9 - i);
            checks++;
            if (q1 !== exp || ovf1 !== (i == 0) || min1 !== (exp == 4'd0)) begin
                errors++; $display("FAIL nd1_dn%0d q=%h ovf=%b min=%b exp=%h/%0d", i, q1, ovf1, min1, exp, (i == 0));
            end
        end
        en1 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_load_count();
        test_reset_mid();
        test_wrap();
        test_saturate();
        test_load_err();
        test_soft_reset();
        test_nd1_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
